intersection_scheduler: RTL and testbench

Two-approach intersection sequencer driving main-road and side-road signal heads from the 1 Hz divided clock. Main road rests in green; a latched side-road demand request triggers a yellow, clearance and side-green cycle, then returns to main. Downstream display logic consumes the per-approach light codes and the shared countdown. The block sits beside the single-approach light and reuses its light encoding and load-then-count-down timing.

---
 rtl/tl_pkg.sv | 45 ++++
 rtl/intersection_scheduler_phase_timer.sv | 42 ++++
 rtl/intersection_scheduler.sv | 162 ++++++++++++++++
 tb/tb_intersection_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: light codes, sequencer phase codes, count type.
// Latency: none (definitions only).
// Backpressure: not applicable.
package tl_pkg;

  // Signal-head light codes, shared by the single-approach light and the intersection.
  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10,
    NONE   = 2'b11
  } light_t;

  // Intersection phase codes; CLR_A/CLR_B are only reachable with the all-red clearance build.
  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    CLR_A    = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4,
    CLR_B    = 3'd5
  } phase_t;

  // Phase durations and remaining-time count are 4-bit tick counts.
  typedef logic [3:0] count_t;

  // Main-road head colour for a given phase code.
  function automatic light_t main_light_of(logic [2:0] p);
    case (p)
      MAIN_GRN: main_light_of = GREEN;
      MAIN_YEL: main_light_of = YELLOW;
      default:  main_light_of = RED;
    endcase
  endfunction

  // Side-road head colour for a given phase code.
  function automatic light_t side_light_of(logic [2:0] p);
    case (p)
      SIDE_GRN: side_light_of = GREEN;
      SIDE_YEL: side_light_of = YELLOW;
      default:  side_light_of = RED;
    endcase
  endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Loadable 4-bit phase down-counter: load wins, otherwise decrements while nonzero and holds at 0.
// Latency: loaded value appears one tick after load; zero reflects the registered count.
// Backpressure: none; the counter simply rests at zero until the next load.
module phase_timer
  import tl_pkg::*;
#(
  parameter logic [3:0] RST_VAL = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       zero
);

  count_t count_q;
  count_t count_d;

  // Next count: explicit load, else saturating decrement toward zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  // Count register with synchronous reset to the initial phase duration.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 4'd0);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection sequencer: main rests green, latched side demand runs yellow/(clear)/side cycle.
// Latency: all outputs registered; phase changes one tick after the running count is seen at zero.
// Backpressure: none; side demand is latched and served on the next main-green expiry.
// Build option: define ALL_RED_EN to insert the CLR_A/CLR_B all-red clearance phases.
module intersection_scheduler
  import tl_pkg::*;
#(
  parameter int MAIN_GREEN_T = 15,
  parameter int SIDE_GREEN_T = 10,
  parameter int YELLOW_T     = 5,
  parameter int ALL_RED_T    = 2
) (
  input  logic       clk_div_1hz,
  input  logic       reset,
  input  logic       side_req,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic [3:0] count_time,
  output logic [2:0] phase,
  output logic       side_ack
);

  localparam count_t MG_T = count_t'(MAIN_GREEN_T);
  localparam count_t SG_T = count_t'(SIDE_GREEN_T);
  localparam count_t YL_T = count_t'(YELLOW_T);
`ifdef ALL_RED_EN
  localparam count_t AR_T = count_t'(ALL_RED_T);
`else
  // Clearance duration has no use when the all-red phases are compiled out.
  logic [3:0] unused_all_red;
  assign unused_all_red = count_t'(ALL_RED_T);
`endif

  logic [2:0] phase_q, phase_d;
  logic       req_q, req_d;
  logic       ack_q, ack_d;
  logic [1:0] main_q, side_q;
  logic       pending;
  logic       tmr_load;
  count_t     tmr_load_val;
  count_t     tmr_count;
  logic       tmr_zero;

  phase_timer #(
    .RST_VAL (MG_T)
  ) u_timer (
    .clk      (clk_div_1hz),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  assign pending = req_q | side_req;

  // Phase transition, timer reload and demand-latch update, evaluated only at count zero.
  always_comb begin
    phase_d      = phase_q;
    req_d        = req_q | side_req;
    ack_d        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = MG_T;
    case (phase_q)
      MAIN_GRN: begin
        // Without demand main rests here with the count parked at zero.
        if (tmr_zero && pending) begin
          phase_d      = MAIN_YEL;
          tmr_load     = 1'b1;
          tmr_load_val = YL_T;
        end
      end
      MAIN_YEL: begin
        if (tmr_zero) begin
`ifdef ALL_RED_EN
          phase_d      = CLR_A;
          tmr_load     = 1'b1;
          tmr_load_val = AR_T;
`else
          // Entering side green serves the demand; a same-tick request is absorbed.
          phase_d      = SIDE_GRN;
          tmr_load     = 1'b1;
          tmr_load_val = SG_T;
          req_d        = 1'b0;
          ack_d        = 1'b1;
`endif
        end
      end
`ifdef ALL_RED_EN
      CLR_A: begin
        if (tmr_zero) begin
          // Entering side green serves the demand; a same-tick request is absorbed.
          phase_d      = SIDE_GRN;
          tmr_load     = 1'b1;
          tmr_load_val = SG_T;
          req_d        = 1'b0;
          ack_d        = 1'b1;
        end
      end
`endif
      SIDE_GRN: begin
        if (tmr_zero) begin
          phase_d      = SIDE_YEL;
          tmr_load     = 1'b1;
          tmr_load_val = YL_T;
        end
      end
      SIDE_YEL: begin
        if (tmr_zero) begin
`ifdef ALL_RED_EN
          phase_d      = CLR_B;
          tmr_load     = 1'b1;
          tmr_load_val = AR_T;
`else
          phase_d      = MAIN_GRN;
          tmr_load     = 1'b1;
          tmr_load_val = MG_T;
`endif
        end
      end
`ifdef ALL_RED_EN
      CLR_B: begin
        if (tmr_zero) begin
          phase_d      = MAIN_GRN;
          tmr_load     = 1'b1;
          tmr_load_val = MG_T;
        end
      end
`endif
      default: begin
        // Unreachable encoding: recover straight to a fresh main green.
        phase_d      = MAIN_GRN;
        tmr_load     = 1'b1;
        tmr_load_val = MG_T;
      end
    endcase
  end

  // Sequencer state and registered head outputs derived from the next phase.
  always_ff @(posedge clk_div_1hz) begin
    if (reset) begin
      phase_q <= MAIN_GRN;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      main_q  <= GREEN;
      side_q  <= RED;
    end else begin
      phase_q <= phase_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      main_q  <= main_light_of(phase_d);
      side_q  <= side_light_of(phase_d);
    end
  end

  assign main_light = main_q;
  assign side_light = side_q;
  assign count_time = tmr_count;
  assign phase      = phase_q;
  assign side_ack   = ack_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Randomized and directed bench for intersection_scheduler against a table-driven phase model.
// Latency: outputs sampled 1 time unit after each rising tick edge.
// Backpressure: not applicable.
module tb_intersection_scheduler;
  import tl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       side_req;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic [3:0] count_time;
  logic [2:0] phase;
  logic       side_ack;

  always #5 clk = ~clk;

  intersection_scheduler dut (
    .clk_div_1hz (clk),
    .reset       (reset),
    .side_req    (side_req),
    .main_light  (main_light),
    .side_light  (side_light),
    .count_time  (count_time),
    .phase       (phase),
    .side_ack    (side_ack)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: current phase, remaining ticks, outstanding demand, ack pulse.
  int m_ph;
  int m_cnt;
  bit m_pend;
  bit m_ack;
  int dur[6];
  int nxt[6];
  int lmain[6];
  int lside[6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic init_tables();
    dur[int'(MAIN_GRN)] = 15;
    dur[int'(MAIN_YEL)] = 5;
    dur[int'(CLR_A)]    = 2;
    dur[int'(SIDE_GRN)] = 10;
    dur[int'(SIDE_YEL)] = 5;
    dur[int'(CLR_B)]    = 2;
    nxt[int'(MAIN_GRN)] = int'(MAIN_YEL);
`ifdef ALL_RED_EN
    nxt[int'(MAIN_YEL)] = int'(CLR_A);
    nxt[int'(SIDE_YEL)] = int'(CLR_B);
`else
    nxt[int'(MAIN_YEL)] = int'(SIDE_GRN);
    nxt[int'(SIDE_YEL)] = int'(MAIN_GRN);
`endif
    nxt[int'(CLR_A)]    = int'(SIDE_GRN);
    nxt[int'(SIDE_GRN)] = int'(SIDE_YEL);
    nxt[int'(CLR_B)]    = int'(MAIN_GRN);
    lmain = '{2, 1, 0, 0, 0, 0};
    lside = '{0, 0, 0, 2, 1, 0};
  endtask

  // Advance the model by one tick given the inputs sampled at that edge.
  task automatic model_step(input bit rq, input bit rs);
    if (rs) begin
      m_ph = int'(MAIN_GRN); m_cnt = 15; m_pend = 1'b0; m_ack = 1'b0;
      return;
    end
    m_ack = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      m_pend = m_pend | rq;
    end else if (m_ph == int'(MAIN_GRN) && !(m_pend || rq)) begin
      // resting on main
    end else begin
      m_ph  = nxt[m_ph];
      m_cnt = dur[m_ph];
      if (m_ph == int'(SIDE_GRN)) begin
        m_pend = 1'b0;
        m_ack  = 1'b1;
      end else begin
        m_pend = m_pend | rq;
      end
    end
  endtask

  task automatic compare_all();
    check("phase", 32'(phase), 32'(m_ph));
    check("count_time", 32'(count_time), 32'(m_cnt));
    check("main_light", 32'(main_light), 32'(lmain[m_ph]));
    check("side_light", 32'(side_light), 32'(lside[m_ph]));
    check("side_ack", 32'(side_ack), 32'(m_ack));
`ifndef ALL_RED_EN
    check("both_red", 32'(main_light == 2'b00 && side_light == 2'b00), 32'd0);
`endif
  endtask

  task automatic tick(input bit rq, input bit rs);
    reset    = rs;
    side_req = rq;
    @(posedge clk);
    model_step(rq, rs);
    #1;
    compare_all();
  endtask

  // Tick until the DUT shows the given phase and count; an expired budget is a failure.
  task automatic run_until(input string tag, input int ph, input int cnt, input bit rq, input int budget);
    int n = 0;
    while (!(phase == 3'(ph) && count_time == 4'(cnt)) && n < budget) begin
      tick(rq, 1'b0);
      n++;
    end
    check(tag, 32'(phase == 3'(ph) && count_time == 4'(cnt)), 32'd1);
  endtask

  initial begin
    int pre_sg;
    init_tables();
    reset = 1'b1;
    side_req = 1'b0;
    m_ph = 0; m_cnt = 0; m_pend = 0; m_ack = 0;
`ifdef ALL_RED_EN
    pre_sg = int'(CLR_A);
`else
    pre_sg = int'(MAIN_YEL);
`endif

    // Reset values.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("rst_count", 32'(count_time), 32'd15);

    // Idle: count runs 15..0 and rests on main green.
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
    check("idle_rest_count", 32'(count_time), 32'd0);

    // Single pulse on the third tick after reset, full side cycle and return.
    tick(1'b0, 1'b1);
    for (int t = 1; t <= 60; t++) tick(t == 3, 1'b0);

    // Request arriving on the tick main is seen at zero moves to yellow on that edge.
    run_until("reach_main_zero", int'(MAIN_GRN), 0, 1'b0, 40);
    tick(1'b1, 1'b0);
    check("yel_on_zero", 32'(phase), 32'(MAIN_YEL));

    // Request during side yellow is served after a full main green.
    run_until("reach_side_yel", int'(SIDE_YEL), 3, 1'b0, 60);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 70; i++) tick(1'b0, 1'b0);

    // Request on the tick entering side green is absorbed.
    run_until("reach_main_zero2", int'(MAIN_GRN), 0, 1'b0, 80);
    tick(1'b1, 1'b0);
    run_until("reach_pre_sg", pre_sg, 0, 1'b0, 40);
    tick(1'b1, 1'b0);
    check("ack_on_sg_entry", 32'(side_ack), 32'd1);
    for (int i = 0; i < 60; i++) tick(1'b0, 1'b0);
    check("absorbed_rest", 32'(phase), 32'(MAIN_GRN));

    // Reset during side green with count 4, with a demand latched beforehand.
    run_until("reach_sg4", int'(SIDE_GRN), 4, 1'b1, 80);
    tick(1'b0, 1'b1);
    check("rst_mid_count", 32'(count_time), 32'd15);
    check("rst_mid_main", 32'(main_light), 32'(GREEN));
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0);
    check("latch_cleared", 32'(phase), 32'(MAIN_GRN));

    // Randomized demand with occasional mid-cycle reset.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(7) == 0, $urandom_range(199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
